// File: rtl/simframe_scheduler.sv
// simframe_scheduler: emits frames of FRAME_BEATS data beats plus one
// metadata beat onto a 512-bit AXI-Stream, paced by a token-bucket limiter
// that gains BYTES_PER_USEC of credit once per microsecond.
module simframe_scheduler #(
   parameter int CLOCK_MHZ  = 250,
   parameter int DATA_BYTES = 64,
   parameter int BUCKET_MAX = 4096
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         START,
   input  logic         STOP,
   input  logic [31:0]  FRAME_COUNT,
   input  logic [31:0]  FRAME_BEATS,
   input  logic [31:0]  BYTES_PER_USEC,
   input  logic [511:0] METADATA,
   output logic [511:0] AXIS_OUT_TDATA,
   output logic         AXIS_OUT_TVALID,
   output logic         AXIS_OUT_TLAST,
   input  logic         AXIS_OUT_TREADY,
   output logic         BUSY,
   output logic [31:0]  FRAMES_SENT
);

   typedef enum logic [1:0] {IDLE, DATA, META} state_t;

   state_t         state;
   logic [31:0]    count_lat;
   logic [31:0]    beats_lat;
   logic [511:0]   meta_lat;
   logic [31:0]    beat_idx;
   logic [15:0]    frame_idx;
   logic [31:0]    frames_sent;
   logic           stop_pending;
   logic [31:0]    credit;
   logic [31:0]    tick_cnt;
   logic [511:0]   tdata;
   logic           tvalid;
   logic           tlast;

   logic           hs;
   logic           tick;
   logic [31:0]    credit_nxt;
   logic           allow;
   logic           last_beat;
   logic           run_done;

   // Add a refill to the bucket, clamping at the ceiling; the 33-bit sum
   // cannot wrap even for a huge BYTES_PER_USEC.
   function automatic logic [31:0] sat_refill(input logic [31:0] c, input logic [31:0] inc);
      logic [32:0] s;
      s = {1'b0, c} + {1'b0, inc};
      if (s > 33'(BUCKET_MAX)) return 32'(BUCKET_MAX);
      return s[31:0];
   endfunction

   // Remove one beat's worth of bytes, never going below zero.
   function automatic logic [31:0] floor_consume(input logic [31:0] c);
      if (c >= 32'(DATA_BYTES)) return c - 32'(DATA_BYTES);
      return 32'd0;
   endfunction

   // Data-beat payload: every 32-bit lane carries {frame, beat}.
   function automatic logic [511:0] lane_fill(input logic [15:0] f, input logic [15:0] b);
      return {16{f, b}};
   endfunction

   // Next-cycle credit and the beat-presentation permission derived from it.
   always_comb begin
      hs         = tvalid && AXIS_OUT_TREADY;
      tick       = (tick_cnt == 32'(CLOCK_MHZ - 1));
      credit_nxt = tick ? sat_refill(credit, BYTES_PER_USEC) : credit;
      if (hs && (BYTES_PER_USEC != 32'd0))
         credit_nxt = floor_consume(credit_nxt);
      allow      = (BYTES_PER_USEC == 32'd0) || (credit_nxt >= 32'(DATA_BYTES));
      last_beat  = (beat_idx == beats_lat - 32'd1);
      run_done   = stop_pending || ((count_lat != 32'd0) && (frames_sent + 32'd1 == count_lat));
   end

   // Frame sequencer, rate limiter and registered stream outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         count_lat    <= '0;
         beats_lat    <= 32'd1;
         meta_lat     <= '0;
         beat_idx     <= '0;
         frame_idx    <= '0;
         frames_sent  <= '0;
         stop_pending <= 1'b0;
         credit       <= '0;
         tick_cnt     <= '0;
         tdata        <= '0;
         tvalid       <= 1'b0;
         tlast        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               credit   <= '0;
               tick_cnt <= '0;
               tvalid   <= 1'b0;
               if (START && !STOP) begin
                  count_lat    <= FRAME_COUNT;
                  beats_lat    <= (FRAME_BEATS == 32'd0) ? 32'd1 : FRAME_BEATS;
                  meta_lat     <= METADATA;
                  frames_sent  <= '0;
                  beat_idx     <= '0;
                  frame_idx    <= '0;
                  stop_pending <= 1'b0;
                  state        <= DATA;
               end
            end

            DATA: begin
               tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
               credit   <= credit_nxt;
               if (STOP) stop_pending <= 1'b1;
               if (hs) begin
                  beat_idx <= beat_idx + 32'd1;
                  tvalid   <= allow;
                  if (last_beat) begin
                     state <= META;
                     if (allow) begin
                        tdata <= meta_lat;
                        tlast <= 1'b1;
                     end
                  end else if (allow) begin
                     tdata <= lane_fill(frame_idx, beat_idx[15:0] + 16'd1);
                     tlast <= 1'b0;
                  end
               end else if (!tvalid && allow) begin
                  tvalid <= 1'b1;
                  tdata  <= lane_fill(frame_idx, beat_idx[15:0]);
                  tlast  <= 1'b0;
               end
            end

            META: begin
               tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
               credit   <= credit_nxt;
               if (STOP) stop_pending <= 1'b1;
               if (hs) begin
                  frames_sent <= frames_sent + 32'd1;
                  frame_idx   <= frame_idx + 16'd1;
                  beat_idx    <= '0;
                  if (run_done) begin
                     state    <= IDLE;
                     tvalid   <= 1'b0;
                     tdata    <= '0;
                     tlast    <= 1'b0;
                     credit   <= '0;
                     tick_cnt <= '0;
                  end else begin
                     meta_lat <= METADATA;
                     state    <= DATA;
                     tvalid   <= allow;
                     if (allow) begin
                        tdata <= lane_fill(frame_idx + 16'd1, 16'd0);
                        tlast <= 1'b0;
                     end
                  end
               end else if (!tvalid && allow) begin
                  tvalid <= 1'b1;
                  tdata  <= meta_lat;
                  tlast  <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign AXIS_OUT_TDATA  = tdata;
   assign AXIS_OUT_TVALID = tvalid;
   assign AXIS_OUT_TLAST  = tlast;
   assign BUSY            = (state != IDLE);
   assign FRAMES_SENT     = frames_sent;

endmodule

// File: tb/tb_simframe_scheduler.sv
// Directed bench for simframe_scheduler: records every transferred beat and
// compares against hand-computed frame layouts, timing and status values.
module tb_simframe_scheduler;

   logic         clk;
   logic         resetn;
   logic         start;
   logic         stop;
   logic [31:0]  frame_count;
   logic [31:0]  frame_beats;
   logic [31:0]  bytes_per_usec;
   logic [511:0] metadata;
   logic [511:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;
   logic         busy;
   logic [31:0]  frames_sent;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [511:0] q_data[$];
   logic         q_last[$];
   int           q_cyc[$];

   localparam logic [511:0] META_A = {16{32'hA5A5_0001}};
   localparam logic [511:0] META_B = {16{32'h5A5A_0002}};

   simframe_scheduler dut (
      .clk             (clk),
      .resetn          (resetn),
      .START           (start),
      .STOP            (stop),
      .FRAME_COUNT     (frame_count),
      .FRAME_BEATS     (frame_beats),
      .BYTES_PER_USEC  (bytes_per_usec),
      .METADATA        (metadata),
      .AXIS_OUT_TDATA  (tdata),
      .AXIS_OUT_TVALID (tvalid),
      .AXIS_OUT_TLAST  (tlast),
      .AXIS_OUT_TREADY (tready),
      .BUSY            (busy),
      .FRAMES_SENT     (frames_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record each beat that will transfer on the coming rising edge.
   always @(negedge clk) begin
      if (resetn && tvalid && tready) begin
         q_data.push_back(tdata);
         q_last.push_back(tlast);
         q_cyc.push_back(cyc);
      end
   end

   function automatic logic [511:0] lanes(input int f, input int b);
      logic [31:0] w;
      w = {f[15:0], b[15:0]};
      return {16{w}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic pulse_start(output int c);
      step();
      c = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         step();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) $display("FAIL reset_ctrl: tvalid=%b tlast=%b busy=%b expected 0 0 0", tvalid, tlast, busy);
      else n_pass++;
      n_checks++;
      if (tdata !== '0) $display("FAIL reset_tdata: got %h expected 0", tdata);
      else n_pass++;
      n_checks++;
      if (frames_sent !== 32'd0) $display("FAIL reset_frames_sent: got %0d expected 0", frames_sent);
      else n_pass++;
   endtask

   task automatic test_unlimited();
      int c;
      bit ok;
      bit bad;
      logic [511:0] exp_d;
      clear_q();
      bytes_per_usec = 0; frame_beats = 4; frame_count = 2; metadata = META_A; tready = 1'b1;
      pulse_start(c);
      wait_idle(100, ok);
      n_checks++;
      if (!ok) $display("FAIL unl_timeout: busy=%b expected 0 within 100 cycles", busy);
      else n_pass++;
      n_checks++;
      if (q_data.size() !== 10) $display("FAIL unl_count: got %0d beats expected 10", q_data.size());
      else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < q_data.size() && i < 10; i++) begin
         exp_d = ((i % 5) == 4) ? META_A : lanes(i / 5, i % 5);
         if (q_data[i] !== exp_d || q_last[i] !== ((i % 5) == 4) || q_cyc[i] !== c + 2 + i) begin
            $display("FAIL unl_beat%0d: got data %h last %b cyc %0d expected data %h last %b cyc %0d",
                     i, q_data[i][31:0], q_last[i], q_cyc[i], exp_d[31:0], ((i % 5) == 4), c + 2 + i);
            bad = 1'b1;
         end
      end
      n_checks++;
      if (bad) $display("FAIL unl_beats: beat sequence differs from expected");
      else n_pass++;
      n_checks++;
      if (q_data.size() < 6 || q_data[2][31:0] !== 32'h0000_0002 || q_data[5][31:0] !== 32'h0001_0000)
         $display("FAIL unl_lanes: beat3/beat6 lanes not 00000002/00010000");
      else n_pass++;
      n_checks++;
      if (frames_sent !== 32'd2 || busy !== 1'b0) $display("FAIL unl_status: frames_sent=%0d busy=%b expected 2 0", frames_sent, busy);
      else n_pass++;
   endtask

   task automatic test_rate();
      int c;
      bit ok;
      clear_q();
      bytes_per_usec = 64; frame_beats = 3; frame_count = 1; tready = 1'b1;
      pulse_start(c);
      wait_idle(2000, ok);
      n_checks++;
      if (!ok || q_cyc.size() !== 4) $display("FAIL rate_count: ok=%b got %0d beats expected 4", ok, q_cyc.size());
      else n_pass++;
      n_checks++;
      if (q_cyc.size() < 4 || q_cyc[0] !== c + 251 || q_cyc[1] !== c + 501 || q_cyc[2] !== c + 751 || q_cyc[3] !== c + 1001)
         $display("FAIL rate_spacing: first beat at offset %0d expected 251 with 250-cycle spacing",
                  (q_cyc.size() > 0) ? q_cyc[0] - c : -1);
      else n_pass++;
   endtask

   task automatic test_burst();
      int c;
      bit ok;
      clear_q();
      bytes_per_usec = 8192; frame_beats = 100; frame_count = 1; tready = 1'b1;
      pulse_start(c);
      wait_idle(1500, ok);
      n_checks++;
      if (!ok || q_cyc.size() !== 101) $display("FAIL burst_count: ok=%b got %0d beats expected 101", ok, q_cyc.size());
      else n_pass++;
      n_checks++;
      if (q_cyc.size() < 65 || q_cyc[63] !== q_cyc[0] + 63 || q_cyc[64] !== q_cyc[0] + 250)
         $display("FAIL burst_shape: beat64 offset %0d beat65 offset %0d expected 63 250",
                  (q_cyc.size() > 64) ? q_cyc[63] - q_cyc[0] : -1, (q_cyc.size() > 64) ? q_cyc[64] - q_cyc[0] : -1);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int c;
      bit ok;
      bit bad;
      logic [511:0] hold_d;
      logic         hold_l;
      logic [511:0] exp_d;
      clear_q();
      bytes_per_usec = 0; frame_beats = 4; frame_count = 2; metadata = META_A; tready = 1'b0;
      pulse_start(c);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tvalid) begin ok = 1'b1; break; end
         step();
      end
      n_checks++;
      if (!ok) $display("FAIL bp_valid: tvalid=%b expected 1 within 20 cycles", tvalid);
      else n_pass++;
      @(negedge clk);
      hold_d = tdata;
      hold_l = tlast;
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tvalid !== 1'b1 || tdata !== hold_d || tlast !== hold_l) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL bp_stall: tvalid=%b data %h expected 1 and stable %h", tvalid, tdata[31:0], hold_d[31:0]);
      else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (!busy) begin ok = 1'b1; break; end
         tready = ($urandom_range(0, 1) == 1);
      end
      tready = 1'b1;
      n_checks++;
      if (!ok || q_data.size() !== 10) $display("FAIL bp_count: ok=%b got %0d beats expected 10", ok, q_data.size());
      else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < q_data.size() && i < 10; i++) begin
         exp_d = ((i % 5) == 4) ? META_A : lanes(i / 5, i % 5);
         if (q_data[i] !== exp_d || q_last[i] !== ((i % 5) == 4)) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL bp_beats: scoreboard differs from expected frame layout");
      else n_pass++;
   endtask

   task automatic test_stop();
      int c;
      bit ok;
      clear_q();
      bytes_per_usec = 0; frame_beats = 8; frame_count = 0; metadata = META_A; tready = 1'b1;
      pulse_start(c);
      while (cyc < c + 22) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_idle(200, ok);
      n_checks++;
      if (!ok || q_data.size() !== 27) $display("FAIL stop_count: ok=%b got %0d beats expected 27", ok, q_data.size());
      else n_pass++;
      n_checks++;
      if (q_data.size() < 27 || q_last[26] !== 1'b1 || q_data[26] !== META_A || q_data[25] !== lanes(2, 7))
         $display("FAIL stop_tail: last beats not frame2 beat7 then metadata");
      else n_pass++;
      n_checks++;
      if (frames_sent !== 32'd3) $display("FAIL stop_frames_sent: got %0d expected 3", frames_sent);
      else n_pass++;
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (busy !== 1'b0 || q_data.size() !== 27 || frames_sent !== 32'd3)
         $display("FAIL stop_idle: busy=%b beats=%0d frames_sent=%0d expected 0 27 3", busy, q_data.size(), frames_sent);
      else n_pass++;
   endtask

   task automatic test_meta_latch();
      int c;
      bit ok;
      clear_q();
      bytes_per_usec = 0; frame_beats = 4; frame_count = 2; metadata = META_A; tready = 1'b1;
      pulse_start(c);
      while (cyc < c + 3) step();
      metadata = META_B;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(100, ok);
      n_checks++;
      if (!ok || q_data.size() !== 10 || frames_sent !== 32'd2)
         $display("FAIL meta_run: ok=%b beats=%0d frames_sent=%0d expected 10 2", ok, q_data.size(), frames_sent);
      else n_pass++;
      n_checks++;
      if (q_data.size() < 10 || q_data[4] !== META_A || q_data[9] !== META_B)
         $display("FAIL meta_values: frame0/frame1 metadata not old/new value");
      else n_pass++;
   endtask

   task automatic test_start_stop();
      clear_q();
      step();
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 10; i++) step();
      n_checks++;
      if (q_data.size() !== 0 || busy !== 1'b0 || tvalid !== 1'b0)
         $display("FAIL start_stop: beats=%0d busy=%b tvalid=%b expected 0 0 0", q_data.size(), busy, tvalid);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int c;
      bit ok;
      clear_q();
      bytes_per_usec = 0; frame_beats = 4; frame_count = 2; metadata = META_A; tready = 1'b1;
      pulse_start(c);
      while (cyc < c + 8) step();
      @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b1 || frames_sent !== 32'd1 || tdata !== lanes(1, 1))
         $display("FAIL rst_pre: tvalid=%b frames_sent=%0d data %h expected 1 1 00010001", tvalid, frames_sent, tdata[31:0]);
      else n_pass++;
      #1;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== 32'd0)
         $display("FAIL rst_async: tvalid=%b busy=%b frames_sent=%0d expected 0 0 0", tvalid, busy, frames_sent);
      else n_pass++;
      step();
      step();
      resetn = 1'b1;
      clear_q();
      bytes_per_usec = 64; frame_beats = 1; frame_count = 1;
      pulse_start(c);
      wait_idle(1000, ok);
      n_checks++;
      if (!ok || q_data.size() !== 2) $display("FAIL rst_rerun_count: ok=%b beats=%0d expected 2", ok, q_data.size());
      else n_pass++;
      n_checks++;
      if (q_data.size() < 1 || q_data[0] !== lanes(0, 0) || q_cyc[0] !== c + 251)
         $display("FAIL rst_rerun_first: data %h offset %0d expected 00000000 251",
                  (q_data.size() > 0) ? q_data[0][31:0] : 32'hFFFF_FFFF, (q_cyc.size() > 0) ? q_cyc[0] - c : -1);
      else n_pass++;
   endtask

   initial begin
      resetn = 1'b0;
      start = 1'b0; stop = 1'b0; tready = 1'b1;
      frame_count = 0; frame_beats = 0; bytes_per_usec = 0; metadata = '0;
      test_reset();
      step();
      step();
      resetn = 1'b1;
      step();
      test_unlimited();
      test_rate();
      test_burst();
      test_backpressure();
      test_stop();
      test_meta_latch();
      test_start_stop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/simframe_scheduler.md
Name: simframe_scheduler

Overview:
Sequences simulated-frame emission onto a 512-bit AXI-Stream. Each frame is FRAME_BEATS data beats followed by one metadata beat, repeated for FRAME_COUNT frames or until stopped. Throughput is paced by a token-bucket rate limiter driven by BYTES_PER_USEC. Its METADATA and BYTES_PER_USEC inputs come from the simframe configuration register block, and its output feeds the LDP emulator datapath.

Parameters:
CLOCK_MHZ, 250, clk cycles per microsecond (credit-tick period)
DATA_BYTES, 64, bytes consumed from the bucket per beat
BUCKET_MAX, 4096, credit saturation ceiling in bytes

Ports:
clk  in  1  clock
resetn  in  1  reset; one clock, reset is asynchronous and active-low
START  in  1  single-cycle pulse; begins a run
STOP  in  1  single-cycle pulse; ends the run after the current frame
FRAME_COUNT  in  32  frames per run; 0 = run until STOP
FRAME_BEATS  in  32  data beats per frame; 0 is treated as 1
BYTES_PER_USEC  in  32  rate limit; 0 = unlimited
METADATA  in  512  metadata beat contents
AXIS_OUT_TDATA  out  512  stream data
AXIS_OUT_TVALID  out  1  stream valid
AXIS_OUT_TLAST  out  1  high on the metadata beat only
AXIS_OUT_TREADY  in  1  stream ready
BUSY  out  1  high whenever the state is not IDLE
FRAMES_SENT  out  32  frames completed in the current run

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: TDATA, TVALID, TLAST, BUSY, FRAMES_SENT. credit=0, tick counter=0, stop_pending=0.
- Reset mid-frame abandons the frame immediately. Downstream is reset together with this block.
- States: IDLE, DATA, META.
- IDLE:
  - START && !STOP: latch FRAME_COUNT, FRAME_BEATS (0 becomes 1) and METADATA; clear FRAMES_SENT, beat_idx, frame_idx, stop_pending; go to DATA next cycle.
  - START and STOP in the same cycle: stay in IDLE.
  - STOP alone is ignored.
  - credit is held at 0, so a run never starts with a burst.
- START outside IDLE is ignored. Latched values are not affected by input changes during a run.
- STOP outside IDLE sets stop_pending. No frame is ever truncated.
- Handshake: a beat transfers on TVALID && TREADY.
  - TVALID rises only when BYTES_PER_USEC==0 or credit >= DATA_BYTES.
  - Once TVALID is high, it and TDATA/TLAST hold until the handshake, whatever happens to credit or BYTES_PER_USEC.
- Outputs are registered. First TVALID is no earlier than 1 cycle after the START cycle. With unlimited rate and TREADY held high, beats are back-to-back with no bubbles, including across DATA/META and frame boundaries.
- DATA:
  - TDATA: every 32-bit lane = {frame_idx[15:0], beat_idx[15:0]}. TLAST=0.
  - On handshake, beat_idx++. When beat_idx reaches FRAME_BEATS-1 and transfers, go to META.
- META:
  - TDATA = latched metadata. TLAST=1.
  - On handshake: FRAMES_SENT++, frame_idx++, beat_idx=0.
  - If stop_pending, or (FRAME_COUNT!=0 and FRAMES_SENT+1==FRAME_COUNT): go to IDLE.
  - Otherwise re-latch METADATA and go to DATA.
- Metadata is latched only at frame start, so METADATA writes mid-frame take effect on the next frame.
- Rate limiter:
  - Tick counter runs 0..CLOCK_MHZ-1 while not IDLE; tick = (counter==CLOCK_MHZ-1).
  - On tick: credit = min(credit + BYTES_PER_USEC, BUCKET_MAX). Sum computed in 33 bits; no wrap.
  - On handshake when BYTES_PER_USEC!=0: credit -= DATA_BYTES, floored at 0.
  - Tick and handshake in the same cycle: saturate first, then subtract.
  - BYTES_PER_USEC==0: credit is not consumed.
  - On entering IDLE: credit and tick counter return to 0.
- FRAMES_SENT holds its final value in IDLE until the next START.
- Counter widths: beat_idx and FRAMES_SENT are 32 bits and wrap modulo 2^32. Lane encoding uses the low 16 bits.

Test Plan:
1. Unlimited rate: BYTES_PER_USEC=0, FRAME_BEATS=4, FRAME_COUNT=2, TREADY=1, START -> 10 consecutive beats. TLAST on beats 5 and 10; beat 3 lanes = 0x0000_0002; beat 6 lanes = 0x0001_0000. FRAMES_SENT=2, then BUSY=0.
2. Rate limit: BYTES_PER_USEC=64, CLOCK_MHZ=250, DATA_BYTES=64, FRAME_BEATS=3, FRAME_COUNT=1 -> 4 beats spaced exactly 250 cycles apart. With BYTES_PER_USEC=8192 the rate is capped at BUCKET_MAX, giving back-to-back bursts of 64 beats.
3. Backpressure: TREADY toggled randomly and held low for 100 cycles with TVALID high -> TDATA/TLAST stable while stalled; no beat lost or duplicated; scoreboard matches case 1.
4. STOP: FRAME_COUNT=0, FRAME_BEATS=8, STOP pulsed on the 3rd data beat of frame 2 -> frame 2 completes with its metadata beat; FRAMES_SENT=3 (frames 0..2); IDLE; a later STOP alone does nothing.
5. Metadata latch and ignored START: METADATA rewritten mid-frame 0 -> frame 0 metadata beat shows the old value, frame 1 shows the new value. START mid-run is ignored; START+STOP together in IDLE -> no TVALID.
6. Reset mid-frame: resetn low on the 2nd data beat -> TVALID, BUSY, FRAMES_SENT all 0 in the same cycle (asynchronous). After release, a fresh START gives frame_idx=0 and credit starts from 0.
